i2c_slave_fsm: RTL

I2C target (slave) state machine: the bus-side responder to the team's I2C master FSM. It decodes START, STOP and repeated START, matches a 7-bit device address, and acknowledges. Writes are mapped onto a register-file port with an auto-incrementing register pointer. Reads return register contents to the master. It serves as the MPU-6050 device model in system simulation and as an FPGA-side register target.

---
 rtl/i2c_slave_fsm.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/i2c_slave_fsm.sv
// rtl/i2c_slave_fsm.sv - I2C target FSM: address match, register-pointer writes, auto-increment reads
module i2c_slave_fsm #(
  parameter int ADDR_SZ = 7,
  parameter int DATA_SZ = 8,
  parameter int REG_SZ  = 8,
  parameter logic [ADDR_SZ-1:0] SLV_ADDR = 7'h68
) (
  input  logic               CLK,
  input  logic               RST_n,
  input  logic               I_SCL,
  input  logic               I_SDA,
  input  logic [DATA_SZ-1:0] I_RD_DATA,
  output logic               O_SDA,
  output logic [REG_SZ-1:0]  O_REG_ADDR,
  output logic               O_WR_EN,
  output logic [DATA_SZ-1:0] O_WR_DATA,
  output logic               O_RD_EN,
  output logic               O_BUSY
);
  localparam int CW = $clog2(DATA_SZ) + 1;
  localparam logic [CW-1:0] BIT_TOP = CW'(DATA_SZ - 1);
  localparam logic [CW-1:0] BYTE_DONE = '1;

  typedef enum logic [3:0] {
    IDLE, ADDR, IGNORE, ACK_ADDR, REG_PTR, ACK_PTR,
    WR_DATA, ACK_WR, RD_DATA, MSTR_ACK, RD_LOAD
  } state_t;

  state_t             state, state_n;
  logic [CW-1:0]      cnt, cnt_n;
  logic [DATA_SZ-1:0] shreg, shreg_n, wr_data_n;
  logic [REG_SZ-1:0]  addr_n;
  logic               sda_n, wr_en_n, busy_n, mack, mack_n;
  logic               scl_s1, scl_s2, scl_prev, sda_s1, sda_s2, sda_prev;
  logic               scl_rise, scl_fall, start, stop;

  // Synchronizers idle at 1 so release from reset never looks like a bus condition
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      {scl_s1, scl_s2, scl_prev} <= 3'b111;
      {sda_s1, sda_s2, sda_prev} <= 3'b111;
    end else begin
      {scl_s1, scl_s2, scl_prev} <= {I_SCL, scl_s1, scl_s2};
      {sda_s1, sda_s2, sda_prev} <= {I_SDA, sda_s1, sda_s2};
    end
  end

  assign scl_rise = scl_s2 & ~scl_prev;
  assign scl_fall = ~scl_s2 & scl_prev;
  assign start    = scl_s2 & scl_prev & sda_prev & ~sda_s2;
  assign stop     = scl_s2 & scl_prev & ~sda_prev & sda_s2;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state      <= IDLE;
      cnt        <= BIT_TOP;
      shreg      <= '0;
      O_SDA      <= 1'b1;
      O_REG_ADDR <= '0;
      O_WR_EN    <= 1'b0;
      O_WR_DATA  <= '0;
      O_BUSY     <= 1'b0;
      mack       <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      shreg      <= shreg_n;
      O_SDA      <= sda_n;
      O_REG_ADDR <= addr_n;
      O_WR_EN    <= wr_en_n;
      O_WR_DATA  <= wr_data_n;
      O_BUSY     <= busy_n;
      mack       <= mack_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    shreg_n   = shreg;
    sda_n     = O_SDA;
    addr_n    = O_REG_ADDR;
    wr_en_n   = 1'b0;
    wr_data_n = O_WR_DATA;
    busy_n    = O_BUSY;
    mack_n    = mack;
    O_RD_EN   = 1'b0;
    if (start) begin
      state_n = ADDR;
      cnt_n   = BIT_TOP;
      sda_n   = 1'b1;
      mack_n  = 1'b0;
    end else if (stop) begin
      state_n = IDLE;
      sda_n   = 1'b1;
      busy_n  = 1'b0;
    end else begin
      case (state)
        IDLE: ;
        ADDR, REG_PTR, WR_DATA: begin
          if (scl_rise) begin
            shreg_n = {shreg[DATA_SZ-2:0], sda_s2};
            cnt_n   = cnt - 1'b1;
          end else if (scl_fall && cnt == BYTE_DONE) begin
            sda_n = 1'b0;
            if (state == ADDR) begin
              if (shreg[ADDR_SZ:1] == SLV_ADDR) begin
                busy_n  = 1'b1;
                state_n = ACK_ADDR;
              end else begin
                sda_n   = 1'b1;
                busy_n  = 1'b0;
                state_n = IGNORE;
              end
            end else if (state == REG_PTR) begin
              addr_n  = shreg[REG_SZ-1:0];
              state_n = ACK_PTR;
            end else begin
              wr_data_n = shreg;
              wr_en_n   = 1'b1;
              state_n   = ACK_WR;
            end
          end
        end
        IGNORE: sda_n = 1'b1;
        ACK_ADDR: begin
          // shreg still holds the address byte, so bit 0 is R/W
          if (scl_fall) begin
            cnt_n = BIT_TOP;
            if (shreg[0]) begin
              O_RD_EN = 1'b1;
              shreg_n = I_RD_DATA;
              sda_n   = I_RD_DATA[DATA_SZ-1];
              state_n = RD_DATA;
            end else begin
              sda_n   = 1'b1;
              state_n = REG_PTR;
            end
          end
        end
        ACK_PTR, ACK_WR: begin
          if (scl_fall) begin
            sda_n   = 1'b1;
            cnt_n   = BIT_TOP;
            state_n = WR_DATA;
            if (state == ACK_WR) addr_n = O_REG_ADDR + 1'b1;
          end
        end
        RD_DATA: begin
          if (scl_fall) begin
            if (cnt == '0) begin
              sda_n   = 1'b1;
              mack_n  = 1'b0;
              state_n = MSTR_ACK;
            end else begin
              shreg_n = {shreg[DATA_SZ-2:0], 1'b0};
              sda_n   = shreg[DATA_SZ-2];
              cnt_n   = cnt - 1'b1;
            end
          end
        end
        MSTR_ACK: begin
          if (scl_rise) begin
            if (sda_s2) begin
              addr_n  = O_REG_ADDR + 1'b1;
              state_n = IGNORE;
            end else begin
              mack_n = 1'b1;
            end
          end else if (scl_fall && mack) begin
            addr_n  = O_REG_ADDR + 1'b1;
            state_n = RD_LOAD;
          end
        end
        RD_LOAD: begin
          // Strobe a cycle after the pointer moves so the read uses the new address
          O_RD_EN = 1'b1;
          shreg_n = I_RD_DATA;
          sda_n   = I_RD_DATA[DATA_SZ-1];
          cnt_n   = BIT_TOP;
          state_n = RD_DATA;
        end
        default: state_n = IDLE;
      endcase
    end
  end
endmodule
